// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the PC sequencer: branch_sel encodings, FSM state
// encoding, the default reset PC, the target-decision record passed from
// pc_target_calc to pc_sequencer, and a word-alignment helper.
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // branch_sel encodings
  localparam logic [1:0] SEL_HALT = 2'b00;  // ebreak: stop fetching
  localparam logic [1:0] SEL_JALR = 2'b01;  // register-indirect jump
  localparam logic [1:0] SEL_SEQ  = 2'b10;  // fall through
  localparam logic [1:0] SEL_BR   = 2'b11;  // pc-relative target

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Outcome of decoding one branch decision.
  typedef struct packed {
    logic        redirect;    // valid pc-relative or JALR redirect
    logic        halt_req;    // valid ebreak
    logic        misaligned;  // redirect target is a trap (trap build only)
    logic [31:0] target;      // word-aligned redirect target
  } pc_decision_t;

  // Clear the two low bits so the PC always stays on a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Combinational target adders and select mux for the PC sequencer.
//   sel_valid  in  qualifies branch_sel
//   branch_sel in  2-bit branch decision (see pc_seq_pkg encodings)
//   ex_pc      in  PC of the resolving instruction
//   imm        in  sign-extended offset
//   rs1        in  JALR base register value
//   decision   out redirect / halt request, trap flag and aligned target
// Build option: PC_MISALIGN_TRAP_EN -- when defined, a redirect target with
// bit[1] set is flagged as misaligned; otherwise the flag is always 0 and the
// target is simply forced onto a word boundary.
// ---------------------------------------------------------------------------
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic         sel_valid,
  input  logic [1:0]   branch_sel,
  input  logic [31:0]  ex_pc,
  input  logic [31:0]  imm,
  input  logic [31:0]  rs1,
  output pc_decision_t decision
);

  logic [31:0] br_tgt;
  logic [31:0] jalr_tgt;
  logic [31:0] raw_tgt;
  logic        is_redirect;

  // 32-bit adds; carry out is intentionally dropped so targets wrap.
  assign br_tgt   = ex_pc + imm;
  assign jalr_tgt = (rs1 + imm) & ~32'h1;

  assign raw_tgt     = (branch_sel == SEL_BR) ? br_tgt : jalr_tgt;
  assign is_redirect = sel_valid && ((branch_sel == SEL_BR) || (branch_sel == SEL_JALR));

  always_comb begin
    decision          = '0;
    decision.redirect = is_redirect;
    decision.halt_req = sel_valid && (branch_sel == SEL_HALT);
    decision.target   = word_align(raw_tgt);
`ifdef PC_MISALIGN_TRAP_EN
    decision.misaligned = is_redirect && raw_tgt[1];
`else
    decision.misaligned = 1'b0;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Instruction-fetch PC sequencer with IDLE/RUN/HALT control, branch/JALR
// redirects, fetch stall accounting and optional misaligned-target trap.
//   clk        in  clock, all state on rising edge
//   rst        in  asynchronous active-high reset
//   sel_valid  in  qualifies branch_sel this cycle
//   branch_sel in  11 branch, 01 JALR, 00 halt, 10 sequential
//   ex_pc      in  PC of the resolving instruction
//   imm        in  sign-extended offset
//   rs1        in  JALR base
//   imem_ready in  instruction memory accepts imem_addr this cycle
//   resume     in  one-cycle pulse leaving HALT
//   imem_req   out fetch request (RUN only)
//   imem_addr  out fetch address (= pc)
//   pc         out current fetch PC
//   pc_plus4   out pc + 4 (wrapping)
//   flush      out one-cycle pulse after an accepted redirect
//   halted     out 1 while in HALT
//   stall_cnt  out saturating count of stalled RUN cycles
//   misalign   out sticky misaligned-target flag (trap build only)
// Build option: PC_MISALIGN_TRAP_EN enables the misaligned-target trap;
// without it misalign is tied to 0.
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel_valid,
  input  logic [1:0]             branch_sel,
  input  logic [31:0]            ex_pc,
  input  logic [31:0]            imm,
  input  logic [31:0]            rs1,
  input  logic                   imem_ready,
  input  logic                   resume,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   flush,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   misalign
);

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  pc_decision_t decision;

  logic [1:0]             state_reg, state_next;
  logic [31:0]            pc_reg, pc_next;
  logic                   flush_reg, flush_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic                   misalign_reg, misalign_next;
  logic [31:0]            pc_inc;

  pc_target_calc u_target_calc (
    .sel_valid  (sel_valid),
    .branch_sel (branch_sel),
    .ex_pc      (ex_pc),
    .imm        (imm),
    .rs1        (rs1),
    .decision   (decision)
  );

  assign pc_inc = pc_reg + 32'd4;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flush_next     = 1'b0;
    stall_cnt_next = stall_cnt_reg;
    misalign_next  = misalign_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_RUN;
      end

      ST_RUN: begin
        if (decision.redirect) begin
          // A redirect wins over fetch progress and does not wait on imem_ready.
          if (decision.misaligned) begin
            state_next    = ST_HALT;
            misalign_next = 1'b1;
          end else begin
            pc_next    = decision.target;
            flush_next = 1'b1;
          end
        end else if (decision.halt_req) begin
          state_next = ST_HALT;
        end else if (imem_ready) begin
          pc_next = pc_inc;
        end else if (stall_cnt_reg != {STALL_CNT_W{1'b1}}) begin
          stall_cnt_next = stall_cnt_reg + STALL_ONE;
        end
      end

      ST_HALT: begin
        // Branch inputs are deliberately ignored here; only resume matters.
        if (resume) begin
          state_next    = ST_RUN;
          pc_next       = pc_inc;
          misalign_next = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      flush_reg     <= 1'b0;
      stall_cnt_reg <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      flush_reg     <= flush_next;
      stall_cnt_reg <= stall_cnt_next;
      misalign_reg  <= misalign_next;
    end
  end

  // All outputs come straight from registers so reset is visible at once.
  assign imem_req  = (state_reg == ST_RUN);
  assign halted    = (state_reg == ST_HALT);
  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign pc_plus4  = pc_inc;
  assign flush     = flush_reg;
  assign stall_cnt = stall_cnt_reg;

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = misalign_reg;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed self-checking bench for pc_sequencer (STALL_CNT_W overridden to 4
// so counter saturation is reachable quickly). Honors PC_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel_valid = 1'b0;
  logic [1:0]    branch_sel = 2'b10;
  logic [31:0]   ex_pc = '0;
  logic [31:0]   imm = '0;
  logic [31:0]   rs1 = '0;
  logic          imem_ready = 1'b1;
  logic          resume = 1'b0;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          flush;
  logic          halted;
  logic [CW-1:0] stall_cnt;
  logic          misalign;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .STALL_CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_valid  (sel_valid),
    .branch_sel (branch_sel),
    .ex_pc      (ex_pc),
    .imm        (imm),
    .rs1        (rs1),
    .imem_ready (imem_ready),
    .resume     (resume),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .flush      (flush),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] e, input logic [31:0] i,
                          input logic [31:0] r);
    sel_valid  = 1'b1;
    branch_sel = sel;
    ex_pc      = e;
    imm        = i;
    rs1        = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pc"},        pc, 32'h0);
    check({tag, " imem_addr"}, imem_addr, 32'h0);
    check({tag, " imem_req"},  {31'b0, imem_req}, 32'h0);
    check({tag, " flush"},     {31'b0, flush}, 32'h0);
    check({tag, " halted"},    {31'b0, halted}, 32'h0);
    check({tag, " stall_cnt"}, {28'b0, stall_cnt}, 32'h0);
    check({tag, " misalign"},  {31'b0, misalign}, 32'h0);
  endtask

  initial begin
    // Reset and IDLE cycle
    #1 rst = 1'b1;
    #7;
    check_reset_outputs("reset");
    #4 rst = 1'b0;   // t=12, before edge at 15: still IDLE
    check("idle imem_req", {31'b0, imem_req}, 32'h0);
    step();
    check("run pc0", pc, 32'h0);
    check("run imem_req", {31'b0, imem_req}, 32'h1);
    check("pc_plus4 at 0", pc_plus4, 32'h4);
    step();
    check("run pc4", pc, 32'h4);
    step();
    check("run pc8", pc, 32'h8);
    check("imem_addr=pc", imem_addr, 32'h8);
    step();
    step();
    check("run pc10", pc, 32'h10);

    // Branch redirect while memory is stalled
    redirect(2'b11, 32'h8, 32'h20, 32'h0);
    imem_ready = 1'b0;
    step();
    check("br pc", pc, 32'h28);
    check("br flush", {31'b0, flush}, 32'h1);
    check("br stall_cnt", {28'b0, stall_cnt}, 32'h0);
    sel_valid = 1'b0;
    imem_ready = 1'b1;
    step();
    check("br flush drop", {31'b0, flush}, 32'h0);
    check("br seq pc", pc, 32'h2C);

    // JALR
    redirect(2'b01, 32'h0, 32'h4, 32'h101);
    step();
    check("jalr pc", pc, 32'h104);
    check("jalr flush", {31'b0, flush}, 32'h1);
    sel_valid = 1'b0;
    step();
    check("jalr seq pc", pc, 32'h108);

    // Misaligned JALR target 0x106
    redirect(2'b01, 32'h0, 32'h4, 32'h102);
    step();
`ifdef PC_MISALIGN_TRAP_EN
    check("trap halted", {31'b0, halted}, 32'h1);
    check("trap misalign", {31'b0, misalign}, 32'h1);
    check("trap pc held", pc, 32'h108);
    check("trap no flush", {31'b0, flush}, 32'h0);
    sel_valid = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("trap resume pc", pc, 32'h10C);
    check("trap resume misalign", {31'b0, misalign}, 32'h0);
`else
    check("align pc", pc, 32'h104);
    check("align misalign", {31'b0, misalign}, 32'h0);
    check("align flush", {31'b0, flush}, 32'h1);
`endif

    // Halt at 0x40, ignored redirect, resume
    redirect(2'b11, 32'h40, 32'h0, 32'h0);
    step();
    check("to 0x40", pc, 32'h40);
    redirect(2'b00, 32'h0, 32'h0, 32'h0);
    step();
    check("halt halted", {31'b0, halted}, 32'h1);
    check("halt imem_req", {31'b0, imem_req}, 32'h0);
    check("halt pc", pc, 32'h40);
    check("halt no flush", {31'b0, flush}, 32'h0);
    redirect(2'b11, 32'h200, 32'h0, 32'h0);
    step();
    check("halt ignore pc", pc, 32'h40);
    check("halt ignore flush", {31'b0, flush}, 32'h0);
    check("halt still", {31'b0, halted}, 32'h1);
    sel_valid = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    check("resume pc", pc, 32'h44);
    check("resume halted", {31'b0, halted}, 32'h0);
    check("resume imem_req", {31'b0, imem_req}, 32'h1);
    check("resume flush", {31'b0, flush}, 32'h0);
    check("resume misalign", {31'b0, misalign}, 32'h0);

    // PC wrap
    redirect(2'b11, 32'hFFFF_FFF0, 32'hC, 32'h0);
    step();
    sel_valid = 1'b0;
    check("wrap start", pc, 32'hFFFF_FFFC);
    check("wrap pc_plus4", pc_plus4, 32'h0);
    step();
    check("wrap pc", pc, 32'h0);

    // Stall counter saturation: 2^4+3 stalled cycles
    imem_ready = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (i == 1)  check("stall 1", {28'b0, stall_cnt}, 32'h1);
      if (i == 10) check("stall 10", {28'b0, stall_cnt}, 32'hA);
    end
    check("stall sat", {28'b0, stall_cnt}, 32'hF);
    check("stall pc held", pc, 32'h0);
    check("stall imem_req", {31'b0, imem_req}, 32'h1);

    // Async reset mid-stall together with resume and redirect
    resume = 1'b1;
    redirect(2'b11, 32'h80, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async rst");
    rst = 1'b0;
    resume = 1'b0;
    sel_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, the width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port sel_valid, input, 1, which qualifies branch_sel for this cycle.
REQ-006 SHALL have port branch_sel, input, 2, the branch decision: 11 = pc-relative target, 01 = JALR, 00 = halt (ebreak), 10 = sequential.
REQ-007 SHALL have port ex_pc, input, 32, the PC of the resolving instruction.
REQ-008 SHALL have port imm, input, 32, the sign-extended offset.
REQ-009 SHALL have port rs1, input, 32, the JALR base.
REQ-010 SHALL have port imem_ready, input, 1, which is 1 when instruction memory accepts imem_addr this cycle.
REQ-011 SHALL have port resume, input, 1, a one-cycle pulse that leaves HALT.
REQ-012 SHALL have port imem_req, output, 1, the fetch request.
REQ-013 SHALL have port imem_addr, output, 32, the fetch address, always equal to pc.
REQ-014 SHALL have port pc, output, 32, the current fetch PC.
REQ-015 SHALL have port pc_plus4, output, 32, equal to pc+4 mod 2^32.
REQ-016 SHALL have port flush, output, 1, a one-cycle pulse the cycle after an accepted redirect.
REQ-017 SHALL have port halted, output, 1, which is 1 in HALT.
REQ-018 SHALL have port stall_cnt, output, STALL_CNT_W, counting stalled cycles.
REQ-019 SHALL have port misalign, output, 1, a sticky misaligned-target flag.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HALT; IDLE->RUN unconditionally one cycle after reset release.
REQ-021 SHALL drive imem_req=1 in RUN only; imem_req=0 in IDLE and HALT.
REQ-022 SHALL compute br_tgt = ex_pc+imm and jalr_tgt = (rs1+imm) & ~32'h1, with 32-bit wrap-around and carries discarded.
REQ-023 SHALL, in RUN with sel_valid and branch_sel 11 or 01, load pc with the selected target and pulse flush next cycle, regardless of imem_ready; a redirect takes priority over sequential advance.
REQ-024 SHALL, in RUN with no redirect and imem_ready=1, advance pc to pc+4; 32'hFFFF_FFFC wraps to 0.
REQ-025 SHALL, in RUN with no redirect and imem_ready=0, hold pc and keep imem_req high, and increment stall_cnt, saturating at all-ones.
REQ-026 SHALL, in RUN with sel_valid and branch_sel 00, enter HALT next cycle with pc held and no flush.
REQ-027 SHALL treat sel_valid with branch_sel 10 as no redirect, following REQ-024 and REQ-025.
REQ-028 SHALL ignore sel_valid and branch_sel in IDLE and HALT.
REQ-029 SHALL, in HALT on resume, load pc+4 and return to RUN, clear misalign, and produce no flush.
REQ-030 SHALL give rst priority over every simultaneous event, including resume and redirect.

Reset
REQ-031 SHALL, on rst assertion and mid-operation, immediately set pc=RESET_PC, state=IDLE, imem_req=0, flush=0, halted=0, stall_cnt=0, misalign=0.

Configuration
REQ-032 SHALL, with PC_MISALIGN_TRAP_EN defined, treat a redirect target with bit[1]=1 as a trap: pc holds, no flush, enter HALT, and set misalign until resume or rst.
REQ-033 SHALL, without PC_MISALIGN_TRAP_EN, force target bits[1:0] to 0 before loading, and tie misalign to 0.

Structure
REQ-034 SHALL take the branch_sel encodings, FSM state encoding and the default RESET_PC from a shared package, pc_seq_pkg.
REQ-035 SHALL place the target adders and select mux in a sub-module, pc_target_calc (combinational); the FSM, PC register and counter stay in pc_sequencer.

Verification
REQ-036 Reset then run with imem_ready=1 -> cycle 1 IDLE with imem_req=0; then pc = 0, 4, 8, with imem_addr=pc.
REQ-037 At pc=0x10, sel_valid with sel=11, ex_pc=0x08, imm=0x20, imem_ready=0 -> pc=0x28 next cycle, flush=1 for exactly one cycle, stall_cnt unchanged.
REQ-038 sel=01, rs1=0x101, imm=0x4 -> pc=0x104; with PC_MISALIGN_TRAP_EN and rs1=0x102 -> HALT, misalign=1, pc held.
REQ-039 sel=00 at pc=0x40 -> halted=1 and imem_req=0 next cycle; redirect while halted is ignored; resume -> pc=0x44, RUN, misalign=0.
REQ-040 pc=0xFFFF_FFFC with imem_ready=1 -> pc=0x0; imem_ready held 0 for 2^STALL_CNT_W+3 cycles -> stall_cnt saturates at all-ones.
REQ-041 rst asserted mid-stall together with resume -> all outputs at reset values asynchronously, before the next clk edge.
